seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the core's single-cycle ALU. It keeps the existing 4-bit op encodings and adds XOR, the three shifts, signed compare, and iterative multiply, divide and remainder. Operands enter through a valid/ready handshake and results leave through one, so the execute stage can stall on long operations. The block sits in the execute stage, between the operand muxes and the writeback register.

---
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU with valid/ready on both sides.
// Single-cycle ops (add/sub/logic/compare/shift) produce a result one edge
// after acceptance; MUL, DIVU and REMU iterate one bit per cycle for WIDTH
// cycles. The result and zero flag are registered and held until consumed.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (srcA, srcB, ALU_control)
//   out_valid/out_ready result handshake (ALU_result, zero)
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  // MUL: acc_q = partial product, a_q = shifted multiplicand, b_q = shifted multiplier.
  // DIVU/REMU: acc_q = partial remainder, a_q = dividend shifting out / quotient
  // shifting in, b_q = divisor.
  logic [WIDTH-1:0] acc_q, a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, out_valid_q, in_ready_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               is_iter;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_nxt, div_quo_nxt, iter_res;

  assign shamt   = srcB[SHAMT_W-1:0];
  assign is_iter = (ALU_control == OP_MUL) || (ALU_control == OP_DIVU) ||
                   (ALU_control == OP_REMU);

  // Single-cycle results, computed straight from the inputs at the accept edge.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_res = '0;
    case (ALU_control)
      OP_ADD:  alu_res = srcA + srcB;
      OP_SUB:  alu_res = srcA - srcB;
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_XOR:  alu_res = srcA ^ srcB;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLL:  alu_res = srcA << shamt;
      OP_SRL:  alu_res = srcA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(srcA) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration step. Restoring division with a zero divisor naturally
  // yields an all-ones quotient and leaves the dividend as the remainder.
  always_comb begin
    mul_acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_shift   = {acc_q, a_q[WIDTH-1]};
    rem_diff    = rem_shift - {1'b0, b_q};
    div_ok      = ~rem_diff[WIDTH];
    div_rem_nxt = div_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    div_quo_nxt = {a_q[WIDTH-2:0], div_ok};
    case (op_q)
      OP_MUL:  iter_res = mul_acc_nxt;
      OP_DIVU: iter_res = div_quo_nxt;
      default: iter_res = div_rem_nxt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter) begin
              op_q    <= ALU_control;
              a_q     <= srcA;
              b_q     <= srcB;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CALC: begin
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= div_rem_nxt;
            a_q   <= div_quo_nxt;
          end
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ALU_result = result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance. Stimulus
// pushes expected result and expected valid cycle; negedge monitors compare.
module tb_seq_alu;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32, e8;
  logic        ov32_prev = 1'b0, ov8_prev = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] srcA, srcB, ALU_result;
  logic [3:0]  ALU_control;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]  srcA8, srcB8, ALU_result8;
  logic [3:0]  ALU_control8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .ALU_control(ALU_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_result(ALU_result), .zero(zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .srcA(srcA8), .srcB(srcB8), .ALU_control(ALU_control8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .ALU_result(ALU_result8), .zero(zero8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; waits for in_ready, then presents one op for one edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      return;
    end
    srcA = a; srcB = b; ALU_control = op; in_valid = 1'b1;
    q32.push_back('{name, exp, cyc + 1 + lat});
    @(posedge clk); #1;
    // Scramble operands after acceptance; the captured op must be unaffected.
    in_valid = 1'b0; srcA = $urandom; srcB = $urandom; ALU_control = 4'($urandom);
  endtask

  task automatic issue8(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int lat);
    int n = 0;
    while (!in_ready8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready8) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      return;
    end
    srcA8 = a; srcB8 = b; ALU_control8 = op; in_valid8 = 1'b1;
    q8.push_back('{name, {24'd0, exp}, cyc + 1 + lat});
    @(posedge clk); #1;
    in_valid8 = 1'b0; srcA8 = 8'($urandom); srcB8 = 8'($urandom); ALU_control8 = 4'($urandom);
  endtask

  // Monitors: latency checked when out_valid rises, data at the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov32_prev) begin
        if (q32.size() == 0) check("unexpected out_valid", 32'd1, 32'd0);
        else check({q32[0].name, " latency"}, cyc, q32[0].cyc);
      end
      if (out_valid && out_ready && q32.size() != 0) begin
        e32 = q32.pop_front();
        check(e32.name, ALU_result, e32.res);
        check({e32.name, " zero"}, {31'd0, zero}, {31'd0, (e32.res == 32'd0)});
      end
    end
    ov32_prev = out_valid;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid8 && !ov8_prev) begin
        if (q8.size() == 0) check("w8 unexpected out_valid", 32'd1, 32'd0);
        else check({q8[0].name, " latency"}, cyc, q8[0].cyc);
      end
      if (out_valid8 && out_ready8 && q8.size() != 0) begin
        e8 = q8.pop_front();
        check(e8.name, {24'd0, ALU_result8}, e8.res);
        check({e8.name, " zero"}, {31'd0, zero8}, {31'd0, (e8.res == 32'd0)});
      end
    end
    ov8_prev = out_valid8;
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b1; srcA = 32'd1; srcB = 32'd1; ALU_control = 4'b0010; out_ready = 1'b1;
    in_valid8 = 1'b0; srcA8 = '0; srcB8 = '0; ALU_control8 = '0; out_ready8 = 1'b1;

    // 1. Reset with in_valid held high.
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", ALU_result, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd1);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst8 in_ready", {31'd0, in_ready8}, 32'd1);
    q32.push_back('{"first ADD", 32'd2, cyc + 1});
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 2-3. Single-cycle ops.
    issue("ADD wrap",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    issue("SUB",       4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 0);
    issue("SLT",       4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         0);
    issue("SLTU",      4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd0,         0);
    issue("SRA",       4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
    issue("SLL",       4'b0100, 32'd1,         32'd31,        32'h8000_0000, 0);
    issue("SRL",       4'b0101, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 0);
    issue("XOR",       4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0);
    issue("AND",       4'b0000, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 0);
    issue("OR",        4'b0001, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_F0F0, 0);
    issue("unknown",   4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 0);

    // 4-5. Iterative ops, including divide by zero.
    issue("MUL",       4'b1001, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 32);
    issue("MUL ones",  4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
    issue("DIVU",      4'b1010, 32'd100,       32'd7,         32'd14,        32);
    issue("REMU",      4'b1011, 32'd100,       32'd7,         32'd2,         32);
    issue("DIVU by0",  4'b1010, 32'd9,         32'd0,         32'hFFFF_FFFF, 32);
    issue("REMU by0",  4'b1011, 32'd9,         32'd0,         32'd9,         32);
    issue("DIVU max",  4'b1010, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32);

    // 6. Back-pressure in DONE; a new request must be ignored.
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    issue("stall ADD", 4'b0010, 32'd3, 32'd4, 32'd7, 0);
    in_valid = 1'b1; srcA = 32'd1; srcB = 32'd1; ALU_control = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      check("stall result", ALU_result, 32'd7);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    check("release out_valid", {31'd0, out_valid}, 32'd0);

    // 7. Reset mid-CALC abandons the op.
    issue("abandoned MUL", 4'b1001, 32'd3, 32'd3, 32'd9, 32);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q32.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    end
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue("DIVU after rst", 4'b1010, 32'd100, 32'd7, 32'd14, 32);

    // 8. WIDTH=8 instance.
    issue8("w8 MUL wrap", 4'b1001, 8'h10, 8'h10, 8'h00, 8);
    issue8("w8 MUL",      4'b1001, 8'h0F, 8'h0F, 8'hE1, 8);
    issue8("w8 DIVU",     4'b1010, 8'd200, 8'd7, 8'd28, 8);
    issue8("w8 REMU",     4'b1011, 8'd200, 8'd7, 8'd4,  8);
    issue8("w8 SRA",      4'b1101, 8'h80,  8'h0B, 8'hF0, 0);

    // Drain both scoreboards with a bound.
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain q32", q32.size(), 32'd0);
    check("drain q8", q8.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
